// File: rtl/uart_tx_serializer_if.sv
// Handshake between the TX byte FIFO and the UART serializer.
// The FIFO side is the master; the serializer is the slave.
interface uart_tx_serializer_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_complete;
   logic       tx_busy;

   modport master (
      output tx_valid,
      output tx_data,
      input  tx_complete,
      input  tx_busy
   );

   modport slave (
      input  tx_valid,
      input  tx_data,
      output tx_complete,
      output tx_busy
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// Serialises FIFO head bytes onto UART_TX as 8N1/8N2 frames and pops the FIFO
// with a one-cycle tx_complete pulse once the last stop bit has finished.
module uart_tx_serializer #(
   parameter int unsigned CLKS_PER_BIT = 1085,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   uart_tx_serializer_if.slave   tx,
   output logic                  UART_TX
);

   localparam int unsigned       BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]     BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
   localparam logic              STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      shift_q, shift_d;
   logic [BW-1:0]   baud_q,  baud_d;
   logic [2:0]      bit_q,   bit_d;
   logic            stop_q,  stop_d;
   logic            line_q,  line_d;
   logic            cmp_q,   cmp_d;
   logic            busy_q,  busy_d;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         baud_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         line_q  <= 1'b1;
         cmp_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         line_q  <= line_d;
         cmp_q   <= cmp_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      stop_d  = stop_q;

      unique case (state_q)
         S_IDLE: begin
            if (tx.tx_valid) begin
               shift_d = tx.tx_data;
               baud_d  = '0;
               bit_d   = '0;
               stop_d  = 1'b0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_q == BAUD_MAX) begin
               baud_d  = '0;
               state_d = S_DATA;
            end else begin
               baud_d  = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_q == BAUD_MAX) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  state_d = S_STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               baud_d  = baud_q + 1'b1;
            end
         end
         S_STOP: begin
            if (baud_q == BAUD_MAX) begin
               baud_d = '0;
               if (stop_q == STOP_LAST) begin
                  stop_d  = 1'b0;
                  state_d = S_DONE;
               end else begin
                  stop_d  = 1'b1;
               end
            end else begin
               baud_d  = baud_q + 1'b1;
            end
         end
         // tx_valid deliberately ignored here so the FIFO pop settles before IDLE
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they align with state_q.
   always_comb begin
      line_d = 1'b1;
      cmp_d  = (state_d == S_DONE);
      busy_d = (state_d != S_IDLE);
      if (state_d == S_START) begin
         line_d = 1'b0;
      end else if (state_d == S_DATA) begin
         line_d = shift_d[0];
      end
   end

   assign UART_TX        = line_q;
   assign tx.tx_complete = cmp_q;
   assign tx.tx_busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four instances cover CPB=4/8/1085
// and one or two stop bits; frames are captured per cycle and checked.
module tb_uart_tx_serializer;

   logic       clk = 1'b0;
   logic [3:0] rst_n;
   logic [3:0] line;

   always #4 clk = ~clk;

   uart_tx_serializer_if if_a ();
   uart_tx_serializer_if if_b ();
   uart_tx_serializer_if if_c ();
   uart_tx_serializer_if if_d ();

   uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_a (
      .clock(clk), .reset(rst_n[0]), .tx(if_a), .UART_TX(line[0]));
   uart_tx_serializer #(.CLKS_PER_BIT(8), .STOP_BITS(1)) u_b (
      .clock(clk), .reset(rst_n[1]), .tx(if_b), .UART_TX(line[1]));
   uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_c (
      .clock(clk), .reset(rst_n[2]), .tx(if_c), .UART_TX(line[2]));
   uart_tx_serializer #(.CLKS_PER_BIT(1085), .STOP_BITS(1)) u_d (
      .clock(clk), .reset(rst_n[3]), .tx(if_d), .UART_TX(line[3]));

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic       cap_line [0:10999];
   logic       cap_cmp  [0:10999];
   logic       cap_busy [0:10999];
   logic [7:0] fifo_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic sig_cmp(input int w);
      case (w)
         0:       return if_a.tx_complete;
         1:       return if_b.tx_complete;
         2:       return if_c.tx_complete;
         default: return if_d.tx_complete;
      endcase
   endfunction

   function automatic logic sig_busy(input int w);
      case (w)
         0:       return if_a.tx_busy;
         1:       return if_b.tx_busy;
         2:       return if_c.tx_busy;
         default: return if_d.tx_busy;
      endcase
   endfunction

   task automatic set_in(input int w, input logic v, input logic [7:0] d);
      case (w)
         0:       begin if_a.tx_valid = v; if_a.tx_data = d; end
         1:       begin if_b.tx_valid = v; if_b.tx_data = d; end
         2:       begin if_c.tx_valid = v; if_c.tx_data = d; end
         default: begin if_d.tx_valid = v; if_d.tx_data = d; end
      endcase
   endtask

   task automatic wait_fall(input string tag, input int w);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (line[w] !== 1'b0 && k < 20);
      check({tag, "_fall_timeout"}, {31'd0, line[w] !== 1'b0}, 32'd0);
   endtask

   // Sample one value per cycle; optionally act as the FIFO or mutate inputs.
   task automatic capture(input int w, input int n, input bit fifo_en, input int mut_at);
      for (int i = 0; i < n; i++) begin
         cap_line[i] = line[w];
         cap_cmp[i]  = sig_cmp(w);
         cap_busy[i] = sig_busy(w);
         if (fifo_en) begin
            if (cap_cmp[i] === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (fifo_q.size() > 0) set_in(w, 1'b1, fifo_q[0]);
            else                   set_in(w, 1'b0, 8'h00);
         end
         if (i == mut_at) set_in(w, 1'b0, 8'h00);
         @(negedge clk);
      end
   endtask

   function automatic logic exp_line(input int cpb, input int stops, input int nfr,
                                     input logic [7:0] b0, input logic [7:0] b1, input int i);
      int         p = (9 + stops) * cpb + 2;
      int         f = i / p;
      int         j = i % p;
      logic [7:0] b = (f == 0) ? b0 : b1;
      if (f >= nfr)    return 1'b1;
      if (j < cpb)     return 1'b0;
      if (j < 9 * cpb) return b[(j / cpb) - 1];
      return 1'b1;
   endfunction

   task automatic analyze(input string tag, input int cpb, input int stops, input int n,
                          input int nfr, input logic [7:0] b0, input logic [7:0] b1);
      int         p = (9 + stops) * cpb + 2;
      int         bad_l = 0, bad_c = 0, bad_b = 0, ncmp = 0, first = -1, busy0 = 0;
      logic [7:0] dec;
      for (int i = 0; i < n; i++) begin
         int  f = i / p;
         int  j = i % p;
         logic ec = (f < nfr) && (j == (9 + stops) * cpb);
         logic eb = (f < nfr) && (j <= (9 + stops) * cpb);
         if (cap_line[i] !== exp_line(cpb, stops, nfr, b0, b1, i)) bad_l++;
         if (cap_cmp[i] !== ec) bad_c++;
         if (cap_busy[i] !== eb) bad_b++;
         if (cap_cmp[i] === 1'b1) begin
            ncmp++;
            if (first < 0) first = i;
         end
         if (i < p && cap_busy[i] === 1'b1) busy0++;
      end
      check({tag, "_line_bad_cycles"}, bad_l, 0);
      check({tag, "_cmp_bad_cycles"}, bad_c, 0);
      check({tag, "_busy_bad_cycles"}, bad_b, 0);
      check({tag, "_cmp_pulses"}, ncmp, nfr);
      check({tag, "_cmp_latency"}, first, (9 + stops) * cpb);
      check({tag, "_busy_len"}, busy0, (9 + stops) * cpb + 1);
      for (int f = 0; f < nfr; f++) begin
         for (int k = 0; k < 8; k++) dec[k] = cap_line[f * p + (k + 1) * cpb + cpb / 2];
         check({tag, $sformatf("_byte%0d", f)}, {24'd0, dec}, {24'd0, (f == 0) ? b0 : b1});
      end
   endtask

   initial begin
      int zrun;
      int seen;

      rst_n = '0;
      for (int w = 0; w < 4; w++) set_in(w, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      for (int w = 0; w < 4; w++) begin
         check($sformatf("rst%0d_line", w), {31'd0, line[w]}, 32'd1);
         check($sformatf("rst%0d_busy", w), {31'd0, sig_busy(w)}, 32'd0);
         check($sformatf("rst%0d_cmp", w), {31'd0, sig_cmp(w)}, 32'd0);
      end
      rst_n = '1;
      @(negedge clk);

      // Single byte 0x55, valid for one sample.
      set_in(0, 1'b1, 8'h55);
      wait_fall("t1", 0);
      set_in(0, 1'b0, 8'h00);
      capture(0, 60, 1'b0, -1);
      analyze("t1", 4, 1, 60, 1, 8'h55, 8'h00);

      // Back-to-back from a model FIFO.
      fifo_q = '{8'hA3, 8'h0F};
      set_in(0, 1'b1, 8'hA3);
      wait_fall("t2", 0);
      capture(0, 110, 1'b1, -1);
      analyze("t2", 4, 1, 110, 2, 8'hA3, 8'h0F);
      check("t2_fifo_left", fifo_q.size(), 0);

      // Input changes after the latch are ignored.
      set_in(0, 1'b1, 8'h81);
      wait_fall("t3", 0);
      capture(0, 60, 1'b0, 10);
      analyze("t3", 4, 1, 60, 1, 8'h81, 8'h00);

      // Reset during data bit 3 (cycles 32..39 after the start edge).
      set_in(1, 1'b1, 8'hB4);
      wait_fall("t4", 1);
      seen = 0;
      for (int i = 0; i < 34; i++) begin
         if (sig_cmp(1) === 1'b1) seen++;
         @(negedge clk);
      end
      rst_n[1] = 1'b0;
      @(negedge clk);
      check("t4_abort_line", {31'd0, line[1]}, 32'd1);
      check("t4_abort_busy", {31'd0, sig_busy(1)}, 32'd0);
      check("t4_abort_cmp", {31'd0, sig_cmp(1)}, 32'd0);
      check("t4_abort_cmp_seen", seen, 0);
      rst_n[1] = 1'b1;
      wait_fall("t4r", 1);
      set_in(1, 1'b0, 8'h00);
      capture(1, 100, 1'b0, -1);
      analyze("t4", 8, 1, 100, 1, 8'hB4, 8'h00);

      // Two stop bits.
      set_in(2, 1'b1, 8'hFF);
      wait_fall("t5", 2);
      set_in(2, 1'b0, 8'h00);
      capture(2, 60, 1'b0, -1);
      analyze("t5", 4, 2, 60, 1, 8'hFF, 8'h00);

      // Default CPB, all-zero byte.
      set_in(3, 1'b1, 8'h00);
      wait_fall("t6", 3);
      set_in(3, 1'b0, 8'h00);
      capture(3, 10870, 1'b0, -1);
      analyze("t6", 1085, 1, 10870, 1, 8'h00, 8'h00);
      zrun = 0;
      while (zrun < 10870 && cap_line[zrun] === 1'b0) zrun++;
      check("t6_low_run", zrun, 9765);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
